// File: rtl/lc3_mem_ctrl_pkg.sv
// lc3_mem_ctrl_pkg: LC-3 bus width and memory-controller state encodings
package lc3_mem_ctrl_pkg;
   localparam int LC3_WIDTH = 16;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR holder sequencing one memory access per MIO_EN request
module lc3_mem_ctrl
   import lc3_mem_ctrl_pkg::*;
#(
   parameter int WIDTH      = LC3_WIDTH,
   parameter int WAIT_LIMIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] main_bus,
   input  logic             GateMDR,
   input  logic             LDMAR,
   input  logic             LDMDR,
   input  logic             MIO_EN,
   input  logic             R_W,
   output logic             R,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             mem_err
);
   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   state_t state, state_nx;
   logic we_q;
   logic [CW-1:0] cnt;
   logic timeout;
   assign timeout   = (WAIT_LIMIT != 0) && (cnt == CW'(WAIT_LIMIT - 1));
   assign main_bus  = GateMDR ? MDR : 'z;
   assign mem_addr  = MAR;
   assign mem_wdata = MDR;
   // state register; reset abandons any access in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else state <= state_nx;
   // next state: start on MIO_EN, finish on ack or timeout, release once MIO_EN drops
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (MIO_EN) state_nx = ST_REQ;
         ST_REQ:  if (mem_ack || timeout) state_nx = ST_DONE;
         ST_DONE: if (!MIO_EN) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end
   // outputs decoded from the registered state, so R rises the cycle after completion
   always_comb begin
      R       = state == ST_DONE;
      mem_req = state == ST_REQ;
      mem_we  = (state == ST_REQ) && we_q;
   end
   // MAR/MDR loads (frozen during REQ), read capture, wait counter and sticky error
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         MAR     <= '0;
         MDR     <= '0;
         we_q    <= 1'b0;
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         if (state == ST_IDLE && MIO_EN) begin
            we_q    <= R_W;
            cnt     <= '0;
            mem_err <= 1'b0;
         end
         if (state == ST_REQ) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (mem_ack && !we_q) MDR <= mem_rdata;
            if (!mem_ack && timeout) mem_err <= 1'b1;
         end
         if (state != ST_REQ && LDMAR) MAR <= main_bus;
         if (state != ST_REQ && LDMDR && !MIO_EN) MDR <= main_bus;
      end
endmodule
